// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the execute-stage divider.
//   WIDTH         operand and result width
//   DIV_LATENCY   clock edges from an accepted start to the edge that raises done
//   CNT_W/count_t iteration counter width and type
//   DIV_ZERO_QUOT quotient returned for a zero divisor
//   div_state_t   divider FSM states
//   magnitude()   absolute value of an operand under signed/unsigned rules
package cpu_pkg;

    localparam int WIDTH       = 32;
    localparam int DIV_LATENCY = WIDTH + 1;
    localparam int CNT_W       = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef logic [CNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } div_state_t;

    // The most negative value maps onto itself. Read as unsigned, that is
    // exactly its magnitude, so MIN / -1 needs no special handling.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic             is_signed);
        return (is_signed && value[WIDTH-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem       partial remainder; always smaller than divisor
//   quot      quotient/dividend shift register; its MSB is the next dividend bit
//   divisor   divisor magnitude
//   next_rem  partial remainder after this iteration
//   next_quot shift register after this iteration; the new quotient bit is in the LSB
module div_step
    import cpu_pkg::*;
(
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quot
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The shifted remainder needs WIDTH+1 bits. Because it is always below
    // 2*divisor, the top bit of the difference is the borrow. When there is
    // no borrow, the difference fits back into WIDTH bits.
    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[WIDTH]) begin
            next_rem  = shifted[WIDTH-1:0];
            next_quot = {quot[WIDTH-2:0], 1'b0};
        end else begin
            next_rem  = trial[WIDTH-1:0];
            next_quot = {quot[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider that sits beside the execute-stage ALU.
//   iClk      clock
//   iNRst     synchronous active-low reset
//   iStart    request; accepted only while idle
//   iSigned   1 = two's-complement operands, 0 = unsigned
//   iRegA     dividend
//   iRegB     divisor
//   oBusy     high in every state except IDLE
//   oDone     one-cycle pulse; results are valid
//   oQuot     quotient
//   oRem      remainder; its sign follows the dividend
//   oDivZero  the divisor was zero
//   oNEG      oQuot[WIDTH-1]
//   oZERO     oQuot == 0
module div_unit
    import cpu_pkg::*;
(
    input  logic             iClk,
    input  logic             iNRst,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iRegA,
    input  logic [WIDTH-1:0] iRegB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oQuot,
    output logic [WIDTH-1:0] oRem,
    output logic             oDivZero,
    output logic             oNEG,
    output logic             oZERO
);

    div_state_t state;
    div_state_t next_state;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] divisor;
    count_t           count;
    logic             is_signed;
    logic             sign_a;
    logic             sign_b;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quot;
    logic [WIDTH-1:0] final_quot;
    logic [WIDTH-1:0] final_rem;

    div_step u_step (
        .rem       (rem),
        .quot      (quot),
        .divisor   (divisor),
        .next_rem  (step_rem),
        .next_quot (step_quot)
    );

    always_ff @(posedge iClk) begin
        if (!iNRst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (iStart) begin
                    next_state = (iRegB == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == count_t'(WIDTH - 1)) begin
                    next_state = FIXUP;
                end
            end
            FIXUP:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The quotient is negative when the operand signs differ. The remainder
    // takes the sign of the dividend, which gives truncating division.
    always_comb begin
        final_quot = (is_signed && (sign_a ^ sign_b)) ? -quot : quot;
        final_rem  = (is_signed && sign_a) ? -rem : rem;
    end

    always_ff @(posedge iClk) begin
        if (!iNRst) begin
            rem       <= '0;
            quot      <= '0;
            divisor   <= '0;
            count     <= '0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            oQuot     <= '0;
            oRem      <= '0;
            oDivZero  <= 1'b0;
            oNEG      <= 1'b0;
            oZERO     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        is_signed <= iSigned;
                        sign_a    <= iRegA[WIDTH-1];
                        sign_b    <= iRegB[WIDTH-1];
                        quot      <= magnitude(iRegA, iSigned);
                        divisor   <= magnitude(iRegB, iSigned);
                        rem       <= '0;
                        count     <= '0;
                        // A zero divisor finishes right away with the raw
                        // dividend as the remainder, whatever the signedness.
                        if (iRegB == '0) begin
                            oQuot    <= DIV_ZERO_QUOT;
                            oRem     <= iRegA;
                            oDivZero <= 1'b1;
                            oNEG     <= DIV_ZERO_QUOT[WIDTH-1];
                            oZERO    <= (DIV_ZERO_QUOT == '0);
                        end else begin
                            oDivZero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem   <= step_rem;
                    quot  <= step_quot;
                    count <= count + 1'b1;
                end
                FIXUP: begin
                    oQuot <= final_quot;
                    oRem  <= final_rem;
                    oNEG  <= final_quot[WIDTH-1];
                    oZERO <= (final_quot == '0);
                end
                default: begin
                end
            endcase
        end
    end

    assign oBusy = (state != IDLE);
    assign oDone = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit. Directed cases are followed
// by random signed/unsigned operand pairs, all checked against an arithmetic
// reference model.
module tb_div_unit;
    import cpu_pkg::*;

    logic             iClk;
    logic             iNRst;
    logic             iStart;
    logic             iSigned;
    logic [WIDTH-1:0] iRegA;
    logic [WIDTH-1:0] iRegB;
    logic             oBusy;
    logic             oDone;
    logic [WIDTH-1:0] oQuot;
    logic [WIDTH-1:0] oRem;
    logic             oDivZero;
    logic             oNEG;
    logic             oZERO;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .iClk     (iClk),
        .iNRst    (iNRst),
        .iStart   (iStart),
        .iSigned  (iSigned),
        .iRegA    (iRegA),
        .iRegB    (iRegB),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oQuot    (oQuot),
        .oRem     (oRem),
        .oDivZero (oDivZero),
        .oNEG     (oNEG),
        .oZERO    (oZERO)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Reference model: plain truncating division on 64-bit integers. A zero
    // divisor returns all ones and the dividend unchanged.
    task automatic modelDiv(input logic [31:0] a, input logic [31:0] b, input logic s,
                            output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one request at a falling edge and returns one falling edge later,
    // after the start edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge iClk);
        iStart  = 1'b1;
        iSigned = s;
        iRegA   = a;
        iRegB   = b;
        @(negedge iClk);
        iStart  = 1'b0;
        iRegA   = $urandom;
        iRegB   = $urandom;
        iSigned = 1'(($urandom));
    endtask

    // Counts clock edges until oDone is visible. The count is capped so that
    // a missing done still terminates.
    task automatic waitDone(output int lat);
        lat = 0;
        while (!oDone && lat < 100) begin
            @(negedge iClk);
            lat++;
        end
    endtask

    task automatic countDones(input int cycles, output int dones);
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge iClk);
            if (oDone) dones++;
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic timing);
        logic [31:0] expQ;
        logic [31:0] expR;
        int          lat;
        modelDiv(a, b, s, expQ, expR);
        applyStimulus(a, b, s);
        if (timing) checkOutput({tag, "_busy_start"}, 32'(oBusy), 32'd1);
        waitDone(lat);
        checkOutput({tag, "_done"}, 32'(oDone), 32'd1);
        // The latency counts edges after the start edge. A zero divisor is
        // done right after the start edge.
        if (timing) checkOutput({tag, "_latency"}, lat, (b == 32'd0) ? 0 : DIV_LATENCY);
        checkOutput({tag, "_quot"}, oQuot, expQ);
        checkOutput({tag, "_rem"}, oRem, expR);
        checkOutput({tag, "_divzero"}, 32'(oDivZero), 32'(b == 32'd0));
        checkOutput({tag, "_neg"}, 32'(oNEG), 32'(expQ[31]));
        checkOutput({tag, "_zero"}, 32'(oZERO), 32'(expQ == 32'd0));
        if (timing) begin
            checkOutput({tag, "_busy_in_done"}, 32'(oBusy), 32'd1);
            @(negedge iClk);
            checkOutput({tag, "_done_pulse"}, 32'(oDone), 32'd0);
            checkOutput({tag, "_busy_after"}, 32'(oBusy), 32'd0);
            checkOutput({tag, "_quot_hold"}, oQuot, expQ);
        end
    endtask

    initial begin
        logic [31:0] specials [4];
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          dones;

        specials[0] = 32'h0000_0000;
        specials[1] = 32'h8000_0000;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h0000_0001;

        iNRst   = 1'b0;
        iStart  = 1'b0;
        iSigned = 1'b0;
        iRegA   = '0;
        iRegB   = '0;
        repeat (3) @(negedge iClk);
        checkOutput("rst_busy", 32'(oBusy), 32'd0);
        checkOutput("rst_done", 32'(oDone), 32'd0);
        checkOutput("rst_divzero", 32'(oDivZero), 32'd0);
        checkOutput("rst_neg", 32'(oNEG), 32'd0);
        checkOutput("rst_zero", 32'(oZERO), 32'd1);
        checkOutput("rst_quot", oQuot, 32'd0);
        checkOutput("rst_rem", oRem, 32'd0);
        iNRst = 1'b1;

        runAndCheck("u100_7", 32'd100, 32'd7, 1'b0, 1'b1);
        runAndCheck("sm100_7", -32'sd100, 32'd7, 1'b1, 1'b1);
        runAndCheck("s100_m7", 32'd100, -32'sd7, 1'b1, 1'b1);
        runAndCheck("u5_0", 32'd5, 32'd0, 1'b0, 1'b1);
        runAndCheck("s5_0", 32'd5, 32'd0, 1'b1, 1'b1);
        runAndCheck("clear_divzero", 32'd100, 32'd7, 1'b0, 1'b1);
        runAndCheck("smin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        runAndCheck("umin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // A second start while busy must be dropped, not queued.
        applyStimulus(32'hFFFF_FFFF, 32'd3, 1'b0);
        repeat (3) @(negedge iClk);
        iStart = 1'b1;
        iRegA  = 32'd9;
        iRegB  = 32'd3;
        @(negedge iClk);
        iStart = 1'b0;
        waitDone(lat);
        checkOutput("ignore_done", 32'(oDone), 32'd1);
        checkOutput("ignore_quot", oQuot, 32'h5555_5555);
        checkOutput("ignore_rem", oRem, 32'd0);
        countDones(40, dones);
        checkOutput("ignore_no_second", dones, 0);

        // Reset during CALC aborts the operation without a done.
        applyStimulus(32'd9, 32'd3, 1'b0);
        repeat (9) @(negedge iClk);
        iNRst = 1'b0;
        @(negedge iClk);
        checkOutput("abort_busy", 32'(oBusy), 32'd0);
        checkOutput("abort_done", 32'(oDone), 32'd0);
        checkOutput("abort_quot", oQuot, 32'd0);
        checkOutput("abort_zero", 32'(oZERO), 32'd1);
        iNRst = 1'b1;
        countDones(40, dones);
        checkOutput("abort_no_done", dones, 0);
        runAndCheck("restart9_3", 32'd9, 32'd3, 1'b0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            a = ($urandom_range(3) == 0) ? specials[$urandom_range(3)] : $urandom;
            b = ($urandom_range(3) == 0) ? specials[$urandom_range(3)] : $urandom;
            if ($urandom_range(1) == 0) b = b >> $urandom_range(31);
            runAndCheck("rand", a, b, 1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
